ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline latch. Consumes the decoded operands and controls
//  held by the ID/EX latch, then computes ALU result, branch target and destination register.
//  Registers all results toward MEM/WB and owns the data-memory request handshake
//  (hold dREN/dWEN until dhit) so the cache sees exactly one request per load/store.
// PARAMETERS
//  WORD_W   32  datapath width; must equal cpu_types_pkg::WORD_W
//  REG_W    5   register-select width
// PORTS
//  CLK           in   1       clock, all state on posedge
//  nRST          in   1       synchronous active-low reset, sampled on posedge CLK
//  ihit          in   1       pipeline advance strobe from icache
//  dhit          in   1       data cache hit / completion for current request
//  flush         in   1       insert bubble on next advance (branch/jump squash)
//  freeze        in   1       hold all state unconditionally (hazard unit)
//  rdat1_in      in   WORD_W  rs operand
//  rdat2_in      in   WORD_W  rt operand; also the store data
//  next_pc_in    in   WORD_W  PC+4 of instruction
//  shamt_in      in   WORD_W  zero-extended shift amount
//  imm_in        in   16      immediate field
//  ALUOp_in      in   aluop_t ALU operation
//  aluSrc_in     in   2       0 rdat2, 1 sext(imm), 2 zext(imm), 3 shamt
//  RegDest_in    in   2       0 rt, 1 rd, 2 r31
//  rt_in, rd_in  in   REG_W   register selects
//  pcSrc_in, bne_in, jal_in, lui_in, memToReg_in, RegWrite_in, dREN_in, dWEN_in, halt_in  in 1  controls
//  dmemload      in   WORD_W  load data from dcache
//  instruction_in in  WORD_W  raw instruction, carried for trace
//  dmemREN, dmemWEN out 1     data request to dcache
//  dmemaddr      out  WORD_W  = latched ALU result
//  dmemstore     out  WORD_W  = latched rdat2
//  mem_stall     out  1       request outstanding; upstream must not advance
//  br_taken_out  out  1       registered branch decision
//  br_target_out out  WORD_W  registered branch target
//  alu_out, load_out, next_pc_out  out WORD_W  results toward WB
//  wsel_out      out  REG_W   destination register
//  RegWrite_out, memToReg_out, halt_out  out 1
//  instruction_out out WORD_W trace copy
// BEHAVIOUR
//  Reset: every output and state bit 0. FSM = IDLE.
//  Update priority per edge: reset > freeze (hold all, FSM included) > advance > hold.
//  advance = ihit & ~mem_stall. On advance with flush=1: load a bubble.
//    Bubble: RegWrite, dREN, dWEN, halt, br_taken = 0; instruction_out = 0.
//  ALU (combinational): B from aluSrc. lui: result = {imm,16'h0}. jal: result = next_pc_in.
//    zero = (ALU raw result == 0). br_taken = pcSrc_in & (zero ^ bne_in).
//    target = next_pc_in + (sext(imm) << 2), modulo 2^WORD_W.
//    Overflow is ignored; no trap.
//  wsel from RegDest (2 -> 5'd31). RegDest=3 is reserved and gives 0.
//  Latency: one cycle, ID/EX to registered outputs.
//  Data FSM, states IDLE, REQ, DONE:
//    IDLE -> REQ on advance of a non-bubble op with dREN|dWEN.
//    REQ: dmemREN/dmemWEN mirror latched dREN/dWEN; mem_stall=1.
//      On dhit: capture dmemload into load_out (loads only), drop requests, go to DONE.
//    DONE: requests low, mem_stall=0.
//      On advance: go to REQ if the new op is a memory op, else IDLE.
//    dhit outside REQ is ignored.
//  mem_stall is combinational: (state==REQ) & ~dhit, so advance may coincide with dhit.
//  flush/freeze during REQ: freeze holds; flush has no effect until advance, which
//    cannot occur before dhit. An issued request is never abandoned.
//  halt_out is sticky once set, until reset.
//  nRST low mid-request: FSM to IDLE and requests drop on that edge.
// STRUCTURE
//  cpu_types_pkg: aluop_t, word_t, and new enums aluSrc_t, regDest_t, exmem_state_t.
//  Sub-module: alu (combinational: aluop_t, a, b -> result, zero, overflow).
//  Instantiated once here.
//  Everything else is inline always_ff / always_comb.
// TESTING
//  1 ADD r3=r1+r2, rdat1=5, rdat2=7, ihit=1 -> next edge alu_out=12, wsel=3, RegWrite_out=1.
//  2 LW, ALU addr 0x100, dhit delayed 3 cycles:
//    -> dmemREN=1 and mem_stall=1 for 3 cycles; load_out=dmemload at dhit; no re-request.
//  3 BEQ, equal operands, next_pc=0x40, imm=0xFFFF -> br_taken_out=1, br_target_out=0x3C.
//    BNE with equal operands -> br_taken_out=0.
//  4 SW with flush=1 on advance -> bubble latched, dmemWEN never asserts, RegWrite_out=0.
//  5 freeze=1 for 2 cycles during REQ with dhit low -> outputs and FSM unchanged.
//    nRST=0 mid-REQ -> all outputs 0, dmemREN=0 next edge.
//  6 JAL next_pc=0x24 -> alu_out=0x24, wsel=31. LUI imm=0xABCD -> alu_out=0xABCD0000.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, ALU operation codes, operand-B source,
// destination-register select and the EX/MEM data-request state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    SRC_RDAT2,
    SRC_SEXT,
    SRC_ZEXT,
    SRC_SHAMT
  } aluSrc_t;

  typedef enum logic [1:0] {
    DEST_RT,
    DEST_RD,
    DEST_R31,
    DEST_RSVD
  } regDest_t;

  typedef enum logic [1:0] {
    EXMEM_IDLE,
    EXMEM_REQ,
    EXMEM_DONE
  } exmem_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. Shifts move operand a by the low bits of b.
// Overflow is reported for signed add/subtract only; callers may ignore it.
module alu
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  aluop_t            aluop,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] result,
  output logic              zero,
  output logic              overflow
);

  localparam int SH_W = $clog2(WORD_W);

  logic signed [WORD_W-1:0] sa;
  logic signed [WORD_W-1:0] sb;

  assign sa = $signed(a);
  assign sb = $signed(b);

  // Operation select and signed overflow detection
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (aluop)
      ALU_SLL:  result = a << b[SH_W-1:0];
      ALU_SRL:  result = a >> b[SH_W-1:0];
      ALU_ADD: begin
        result   = a + b;
        overflow = (sa[WORD_W-1] == sb[WORD_W-1]) && (result[WORD_W-1] != sa[WORD_W-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (sa[WORD_W-1] != sb[WORD_W-1]) && (result[WORD_W-1] != sa[WORD_W-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(WORD_W-1){1'b0}}, (sa < sb)};
      ALU_SLTU: result = {{(WORD_W-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM latch: ALU, branch decision/target, destination
// select, and the single-shot data-cache request handshake. WORD_W must match
// cpu_types_pkg::WORD_W.
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic              freeze,
  input  logic [WORD_W-1:0] rdat1_in,
  input  logic [WORD_W-1:0] rdat2_in,
  input  logic [WORD_W-1:0] next_pc_in,
  input  logic [WORD_W-1:0] shamt_in,
  input  logic [15:0]       imm_in,
  input  aluop_t            ALUOp_in,
  input  logic [1:0]        aluSrc_in,
  input  logic [1:0]        RegDest_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              pcSrc_in,
  input  logic              bne_in,
  input  logic              jal_in,
  input  logic              lui_in,
  input  logic              memToReg_in,
  input  logic              RegWrite_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              halt_in,
  input  logic [WORD_W-1:0] dmemload,
  input  logic [WORD_W-1:0] instruction_in,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              br_taken_out,
  output logic [WORD_W-1:0] br_target_out,
  output logic [WORD_W-1:0] alu_out,
  output logic [WORD_W-1:0] load_out,
  output logic [WORD_W-1:0] next_pc_out,
  output logic [REG_W-1:0]  wsel_out,
  output logic              RegWrite_out,
  output logic              memToReg_out,
  output logic              halt_out,
  output logic [WORD_W-1:0] instruction_out
);

  exmem_state_t state;
  exmem_state_t state_next;

  logic [WORD_W-1:0] b_ex;
  logic [WORD_W-1:0] alu_raw_ex;
  logic [WORD_W-1:0] result_ex;
  logic [WORD_W-1:0] target_ex;
  logic [REG_W-1:0]  wsel_ex;
  logic              zero_ex;
  logic              ovf_ex;
  logic              br_taken_ex;
  logic              mem_op_ex;
  logic              req_active;
  logic              advance;
  logic              unused_ovf;

  logic [WORD_W-1:0] alu_p0;
  logic [WORD_W-1:0] store_p0;
  logic [WORD_W-1:0] npc_p0;
  logic [WORD_W-1:0] tgt_p0;
  logic [WORD_W-1:0] instr_p0;
  logic [WORD_W-1:0] load_p0;
  logic [REG_W-1:0]  wsel_p0;
  logic              rw_p0;
  logic              m2r_p0;
  logic              dren_p0;
  logic              dwen_p0;
  logic              halt_p0;
  logic              br_p0;

  // Operand B source select
  always_comb begin
    b_ex = rdat2_in;
    case (aluSrc_t'(aluSrc_in))
      SRC_RDAT2: b_ex = rdat2_in;
      SRC_SEXT:  b_ex = {{(WORD_W-16){imm_in[15]}}, imm_in};
      SRC_ZEXT:  b_ex = {{(WORD_W-16){1'b0}}, imm_in};
      SRC_SHAMT: b_ex = shamt_in;
      default:   b_ex = rdat2_in;
    endcase
  end

  alu #(.WORD_W(WORD_W)) u_alu (
    .aluop    (ALUOp_in),
    .a        (rdat1_in),
    .b        (b_ex),
    .result   (alu_raw_ex),
    .zero     (zero_ex),
    .overflow (ovf_ex)
  );

  // Arithmetic overflow never traps in this pipeline
  assign unused_ovf = ovf_ex;

  // Final result: lui and jal override the ALU; zero still comes from the raw ALU value
  always_comb begin
    result_ex = alu_raw_ex;
    if (lui_in)
      result_ex = {imm_in, {(WORD_W-16){1'b0}}};
    else if (jal_in)
      result_ex = next_pc_in;
  end

  // Destination register select; the reserved encoding writes r0
  always_comb begin
    wsel_ex = '0;
    case (regDest_t'(RegDest_in))
      DEST_RT:   wsel_ex = rt_in;
      DEST_RD:   wsel_ex = rd_in;
      DEST_R31:  wsel_ex = '1;
      default:   wsel_ex = '0;
    endcase
  end

  assign br_taken_ex = pcSrc_in & (zero_ex ^ bne_in);
  assign target_ex   = next_pc_in + {{(WORD_W-18){imm_in[15]}}, imm_in, 2'b00};

  // A flushed op enters as a bubble and never issues a memory request
  assign mem_op_ex  = ~flush & (dREN_in | dWEN_in);
  assign req_active = (state == EXMEM_REQ);
  assign mem_stall  = req_active & ~dhit;
  assign advance    = ihit & ~mem_stall;

  // Request FSM next state; a completing request may hand straight over to the next one
  always_comb begin
    state_next = state;
    if (!freeze) begin
      case (state)
        EXMEM_IDLE, EXMEM_DONE: begin
          if (advance)
            state_next = mem_op_ex ? EXMEM_REQ : EXMEM_IDLE;
        end
        EXMEM_REQ: begin
          if (dhit) begin
            if (advance)
              state_next = mem_op_ex ? EXMEM_REQ : EXMEM_IDLE;
            else
              state_next = EXMEM_DONE;
          end
        end
        default: state_next = EXMEM_IDLE;
      endcase
    end
  end

  // Request FSM state register
  always_ff @(posedge CLK) begin
    if (!nRST)
      state <= EXMEM_IDLE;
    else
      state <= state_next;
  end

  // EX/MEM latch: freeze holds everything, otherwise load on advance and capture load data on dhit
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      alu_p0   <= '0;
      store_p0 <= '0;
      npc_p0   <= '0;
      tgt_p0   <= '0;
      instr_p0 <= '0;
      load_p0  <= '0;
      wsel_p0  <= '0;
      rw_p0    <= 1'b0;
      m2r_p0   <= 1'b0;
      dren_p0  <= 1'b0;
      dwen_p0  <= 1'b0;
      halt_p0  <= 1'b0;
      br_p0    <= 1'b0;
    end else if (!freeze) begin
      if (req_active && dhit && dren_p0)
        load_p0 <= dmemload;
      if (advance) begin
        alu_p0   <= result_ex;
        store_p0 <= rdat2_in;
        npc_p0   <= next_pc_in;
        tgt_p0   <= target_ex;
        wsel_p0  <= wsel_ex;
        m2r_p0   <= memToReg_in;
        if (flush) begin
          rw_p0    <= 1'b0;
          dren_p0  <= 1'b0;
          dwen_p0  <= 1'b0;
          br_p0    <= 1'b0;
          instr_p0 <= '0;
        end else begin
          rw_p0    <= RegWrite_in;
          dren_p0  <= dREN_in;
          dwen_p0  <= dWEN_in;
          br_p0    <= br_taken_ex;
          instr_p0 <= instruction_in;
          halt_p0  <= halt_p0 | halt_in;
        end
      end
    end
  end

  assign dmemREN         = req_active & dren_p0;
  assign dmemWEN         = req_active & dwen_p0;
  assign dmemaddr        = alu_p0;
  assign dmemstore       = store_p0;
  assign br_taken_out    = br_p0;
  assign br_target_out   = tgt_p0;
  assign alu_out         = alu_p0;
  assign load_out        = load_p0;
  assign next_pc_out     = npc_p0;
  assign wsel_out        = wsel_p0;
  assign RegWrite_out    = rw_p0;
  assign memToReg_out    = m2r_p0;
  assign halt_out        = halt_p0;
  assign instruction_out = instr_p0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vectors, a behavioural model compared on
// every falling edge, and literal expectations for the key scenarios.
module tb_ex_mem_stage;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        nRST, ihit, dhit, flush, freeze;
  logic [31:0] rdat1_in, rdat2_in, next_pc_in, shamt_in, dmemload, instruction_in;
  logic [15:0] imm_in;
  aluop_t      ALUOp_in;
  logic [1:0]  aluSrc_in, RegDest_in;
  logic [4:0]  rt_in, rd_in;
  logic        pcSrc_in, bne_in, jal_in, lui_in, memToReg_in, RegWrite_in;
  logic        dREN_in, dWEN_in, halt_in;

  logic        dmemREN, dmemWEN, mem_stall, br_taken_out;
  logic        RegWrite_out, memToReg_out, halt_out;
  logic [31:0] dmemaddr, dmemstore, br_target_out, alu_out, load_out, next_pc_out;
  logic [31:0] instruction_out;
  logic [4:0]  wsel_out;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  ex_mem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(clk), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush), .freeze(freeze),
    .rdat1_in(rdat1_in), .rdat2_in(rdat2_in), .next_pc_in(next_pc_in), .shamt_in(shamt_in),
    .imm_in(imm_in), .ALUOp_in(ALUOp_in), .aluSrc_in(aluSrc_in), .RegDest_in(RegDest_in),
    .rt_in(rt_in), .rd_in(rd_in), .pcSrc_in(pcSrc_in), .bne_in(bne_in), .jal_in(jal_in),
    .lui_in(lui_in), .memToReg_in(memToReg_in), .RegWrite_in(RegWrite_in),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in), .dmemload(dmemload),
    .instruction_in(instruction_in), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .br_taken_out(br_taken_out), .br_target_out(br_target_out), .alu_out(alu_out),
    .load_out(load_out), .next_pc_out(next_pc_out), .wsel_out(wsel_out),
    .RegWrite_out(RegWrite_out), .memToReg_out(memToReg_out), .halt_out(halt_out),
    .instruction_out(instruction_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_alu = '0, m_store = '0, m_npc = '0, m_tgt = '0, m_instr = '0, m_load = '0;
  logic [4:0]  m_wsel = '0;
  logic        m_rw = 1'b0, m_m2r = 1'b0, m_dren = 1'b0, m_dwen = 1'b0;
  logic        m_halt = 1'b0, m_br = 1'b0, m_pend = 1'b0;
  wire         m_adv = ihit & ~(m_pend & ~dhit);

  function automatic logic [31:0] operand_b();
    case (aluSrc_in)
      2'd0:    return rdat2_in;
      2'd1:    return {{16{imm_in[15]}}, imm_in};
      2'd2:    return {16'h0000, imm_in};
      default: return shamt_in;
    endcase
  endfunction

  function automatic logic [31:0] raw_alu();
    logic [31:0] a, b;
    a = rdat1_in;
    b = operand_b();
    case (ALUOp_in)
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    if (lui_in) return {imm_in, 16'h0000};
    if (jal_in) return next_pc_in;
    return raw_alu();
  endfunction

  function automatic logic [4:0] model_wsel();
    case (RegDest_in)
      2'd0:    return rt_in;
      2'd1:    return rd_in;
      2'd2:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic model_br();
    return pcSrc_in & ((raw_alu() == 32'd0) != bne_in);
  endfunction

  function automatic logic [31:0] model_tgt();
    return next_pc_in + ({{16{imm_in[15]}}, imm_in} << 2);
  endfunction

  always @(posedge clk) begin
    if (!nRST) begin
      m_alu <= '0; m_store <= '0; m_npc <= '0; m_tgt <= '0; m_instr <= '0; m_load <= '0;
      m_wsel <= '0; m_rw <= 1'b0; m_m2r <= 1'b0; m_dren <= 1'b0; m_dwen <= 1'b0;
      m_halt <= 1'b0; m_br <= 1'b0; m_pend <= 1'b0;
    end else if (!freeze) begin
      if (m_pend && dhit) begin
        if (m_dren) m_load <= dmemload;
        m_pend <= 1'b0;
      end
      if (m_adv) begin
        m_alu   <= model_result();
        m_store <= rdat2_in;
        m_npc   <= next_pc_in;
        m_tgt   <= model_tgt();
        m_wsel  <= model_wsel();
        m_m2r   <= memToReg_in;
        m_rw    <= flush ? 1'b0 : RegWrite_in;
        m_dren  <= flush ? 1'b0 : dREN_in;
        m_dwen  <= flush ? 1'b0 : dWEN_in;
        m_br    <= flush ? 1'b0 : model_br();
        m_instr <= flush ? 32'd0 : instruction_in;
        m_halt  <= m_halt | (~flush & halt_in);
        m_pend  <= ~flush & (dREN_in | dWEN_in);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_alu_out", alu_out, m_alu);
      chk("m_dmemstore", dmemstore, m_store);
      chk("m_next_pc_out", next_pc_out, m_npc);
      chk("m_br_target", br_target_out, m_tgt);
      chk("m_instruction", instruction_out, m_instr);
      chk("m_load_out", load_out, m_load);
      chk("m_wsel", 32'(wsel_out), 32'(m_wsel));
      chk("m_regwrite", 32'(RegWrite_out), 32'(m_rw));
      chk("m_memtoreg", 32'(memToReg_out), 32'(m_m2r));
      chk("m_halt", 32'(halt_out), 32'(m_halt));
      chk("m_br_taken", 32'(br_taken_out), 32'(m_br));
      chk("m_dmemREN", 32'(dmemREN), 32'(m_pend & m_dren));
      chk("m_dmemWEN", 32'(dmemWEN), 32'(m_pend & m_dwen));
      chk("m_mem_stall", 32'(mem_stall), 32'(m_pend & ~dhit));
      chk("m_dmemaddr", dmemaddr, m_alu);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    ihit = 1'b1; dhit = 1'b0; flush = 1'b0; freeze = 1'b0;
    rdat1_in = '0; rdat2_in = '0; next_pc_in = '0; shamt_in = '0; imm_in = '0;
    ALUOp_in = ALU_ADD; aluSrc_in = 2'd0; RegDest_in = 2'd0; rt_in = '0; rd_in = '0;
    pcSrc_in = 1'b0; bne_in = 1'b0; jal_in = 1'b0; lui_in = 1'b0; memToReg_in = 1'b0;
    RegWrite_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
    dmemload = '0; instruction_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    nRST = 1'b0;
    ihit = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    step();
    chk("reset_alu_out", alu_out, 32'd0);
    chk("reset_dmemREN", 32'(dmemREN), 32'd0);
    chk("reset_mem_stall", 32'(mem_stall), 32'd0);
    chk("reset_halt", 32'(halt_out), 32'd0);
    nRST = 1'b1;

    // ADD r3 = 5 + 7
    clear_inputs();
    rdat1_in = 32'd5; rdat2_in = 32'd7; RegDest_in = 2'd1; rd_in = 5'd3; rt_in = 5'd2;
    RegWrite_in = 1'b1; instruction_in = 32'h0022_1820; next_pc_in = 32'h4;
    step();
    chk("add_alu", alu_out, 32'd12);
    chk("add_wsel", 32'(wsel_out), 32'd3);
    chk("add_regwrite", 32'(RegWrite_out), 32'd1);
    chk("add_instr", instruction_out, 32'h0022_1820);

    // LW from 0x100, dhit after three stalled cycles
    clear_inputs();
    rdat1_in = 32'h100; aluSrc_in = 2'd1; imm_in = 16'h0; dREN_in = 1'b1; memToReg_in = 1'b1;
    RegWrite_in = 1'b1; rt_in = 5'd4; instruction_in = 32'h8C04_0000;
    step();
    clear_inputs();
    rdat1_in = 32'd1; rdat2_in = 32'd1; RegWrite_in = 1'b1; RegDest_in = 2'd1; rd_in = 5'd9;
    for (int i = 0; i < 3; i++) begin
      chk("lw_ren_wait", 32'(dmemREN), 32'd1);
      chk("lw_stall_wait", 32'(mem_stall), 32'd1);
      chk("lw_addr", dmemaddr, 32'h100);
      step();
    end
    dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
    #1;
    chk("lw_stall_at_dhit", 32'(mem_stall), 32'd0);
    step();
    dhit = 1'b0;
    #1;
    chk("lw_load_out", load_out, 32'hDEAD_BEEF);
    chk("lw_no_rerequest", 32'(dmemREN), 32'd0);
    chk("lw_next_op_alu", alu_out, 32'd2);
    step();
    chk("lw_still_idle", 32'(dmemREN), 32'd0);

    // BEQ taken with backward offset, then BNE not taken
    clear_inputs();
    ALUOp_in = ALU_SUB; rdat1_in = 32'd9; rdat2_in = 32'd9; pcSrc_in = 1'b1;
    next_pc_in = 32'h40; imm_in = 16'hFFFF;
    step();
    chk("beq_taken", 32'(br_taken_out), 32'd1);
    chk("beq_target", br_target_out, 32'h3C);
    bne_in = 1'b1;
    step();
    chk("bne_not_taken", 32'(br_taken_out), 32'd0);

    // SW squashed by flush
    clear_inputs();
    rdat1_in = 32'h200; aluSrc_in = 2'd1; imm_in = 16'd4; rdat2_in = 32'h55; dWEN_in = 1'b1;
    flush = 1'b1; instruction_in = 32'hAC05_0004; halt_in = 1'b1;
    step();
    chk("flush_wen", 32'(dmemWEN), 32'd0);
    chk("flush_regwrite", 32'(RegWrite_out), 32'd0);
    chk("flush_instr", instruction_out, 32'd0);
    chk("flush_halt", 32'(halt_out), 32'd0);
    clear_inputs();
    step();
    chk("flush_wen_after", 32'(dmemWEN), 32'd0);

    // SW issued, then freeze mid-request, then reset mid-request
    clear_inputs();
    rdat1_in = 32'h200; aluSrc_in = 2'd1; imm_in = 16'd8; rdat2_in = 32'h55; dWEN_in = 1'b1;
    instruction_in = 32'hAC05_0008;
    step();
    chk("sw_wen", 32'(dmemWEN), 32'd1);
    clear_inputs();
    freeze = 1'b1; rdat1_in = 32'h777; RegWrite_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("freeze_wen", 32'(dmemWEN), 32'd1);
      chk("freeze_addr", dmemaddr, 32'h208);
      chk("freeze_store", dmemstore, 32'h55);
      chk("freeze_stall", 32'(mem_stall), 32'd1);
    end
    freeze = 1'b0;
    nRST = 1'b0;
    step();
    chk("rst_mid_wen", 32'(dmemWEN), 32'd0);
    chk("rst_mid_stall", 32'(mem_stall), 32'd0);
    chk("rst_mid_alu", alu_out, 32'd0);
    chk("rst_mid_store", dmemstore, 32'd0);
    nRST = 1'b1;

    // JAL and LUI
    clear_inputs();
    jal_in = 1'b1; next_pc_in = 32'h24; RegDest_in = 2'd2; RegWrite_in = 1'b1;
    step();
    chk("jal_alu", alu_out, 32'h24);
    chk("jal_wsel", 32'(wsel_out), 32'd31);
    clear_inputs();
    lui_in = 1'b1; imm_in = 16'hABCD; aluSrc_in = 2'd2; RegDest_in = 2'd3; rd_in = 5'd7;
    step();
    chk("lui_alu", alu_out, 32'hABCD_0000);
    chk("rsvd_wsel", 32'(wsel_out), 32'd0);

    // Back-to-back loads: completion coincides with advance of the next load
    clear_inputs();
    rdat1_in = 32'h300; dREN_in = 1'b1;
    step();
    clear_inputs();
    rdat1_in = 32'h310; dREN_in = 1'b1;
    step();
    dhit = 1'b1; dmemload = 32'h1234_5678;
    step();
    dhit = 1'b0;
    #1;
    chk("b2b_load1", load_out, 32'h1234_5678);
    chk("b2b_ren2", 32'(dmemREN), 32'd1);
    chk("b2b_addr2", dmemaddr, 32'h310);
    clear_inputs();
    dhit = 1'b1; dmemload = 32'hCAFE_F00D;
    step();
    chk("b2b_load2", load_out, 32'hCAFE_F00D);
    chk("b2b_ren_drop", 32'(dmemREN), 32'd0);
    dmemload = 32'hFFFF_0000;
    step();
    chk("idle_dhit_ignored", load_out, 32'hCAFE_F00D);

    // Sticky halt
    clear_inputs();
    halt_in = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    chk("halt_sticky", 32'(halt_out), 32'd1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
